// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared FE queue packet layout, processor configuration and pointer compare helpers
// Contents: bp_params_e, bp_fe_queue_s, fe_queue_width_p, fe_queue_fifo_els(), `BP_BE_PTR_FULL / `BP_BE_PTR_EMPTY
`ifndef BP_BE_PKG_MACROS
`define BP_BE_PKG_MACROS
// pointers carry a wrap bit as MSB: full when only the wrap bit differs
`define BP_BE_PTR_FULL(a, b, w) ((((a) ^ (b))) == {1'b1, {((w)-1){1'b0}}})
`define BP_BE_PTR_EMPTY(a, b) ((a) == (b))
`endif
package bp_be_pkg;
   typedef enum logic {e_bp_default_cfg, e_bp_large_cfg} bp_params_e;
   localparam int vaddr_width_p = 39;
   localparam int branch_metadata_fwd_width_p = 35;
   typedef struct packed {
      logic [1:0] msg_type;
      logic [vaddr_width_p-1:0] pc;
      logic [31:0] instr;
      logic [branch_metadata_fwd_width_p-1:0] branch_metadata_fwd;
   } bp_fe_queue_s;
   localparam int fe_queue_width_p = $bits(bp_fe_queue_s);
   function automatic int fe_queue_fifo_els(input bp_params_e cfg);
      return (cfg == e_bp_large_cfg) ? 16 : 8;
   endfunction
endpackage

// File: rtl/bp_be_ckpt_ptr.sv
// bp_be_ckpt_ptr: wrapping pointer register with increment and load
// Ports: clk_i, reset_i (sync, active-high), inc_i, load_v_i, load_i, ptr_o
module bp_be_ckpt_ptr #(
   parameter int width_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               inc_i,
   input  logic               load_v_i,
   input  logic [width_p-1:0] load_i,
   output logic [width_p-1:0] ptr_o
);
   always_ff @(posedge clk_i)
      ptr_o <= reset_i ? '0 : load_v_i ? load_i : ptr_o + width_p'(inc_i);
endmodule

// File: rtl/bsg_mem_1r1w.sv
// bsg_mem_1r1w: els_p x width_p storage, synchronous write, asynchronous read
// Ports: w_clk_i, w_v_i/w_addr_i/w_data_i write port; r_addr_i/r_data_o read port
module bsg_mem_1r1w #(
   parameter int width_p = 8,
   parameter int els_p = 8
) (
   input  logic                     w_clk_i,
   input  logic                     w_v_i,
   input  logic [$clog2(els_p)-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [$clog2(els_p)-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);
   logic [width_p-1:0] mem [els_p];
   always_ff @(posedge w_clk_i)
      if (w_v_i) mem[w_addr_i] <= w_data_i;
   assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/bp_be_fe_checkpoint_fifo.sv
// bp_be_fe_checkpoint_fifo: FE packet FIFO that keeps issued entries until commit, supporting roll and clear
// Ports: clk_i, reset_i; clr_v_i, deq_v_i, roll_v_i control; fe_queue_i/fe_queue_v_i/fe_queue_ready_o enqueue;
//        fe_queue_o/fe_queue_v_o/fe_queue_yumi_i issue
// Option: BP_BE_FE_QUEUE_BYPASS_EN forwards fe_queue_i to fe_queue_o when issue-empty
module bp_be_fe_checkpoint_fifo
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int els_p = fe_queue_fifo_els(bp_params_p)
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         clr_v_i,
   input  logic         deq_v_i,
   input  logic         roll_v_i,
   input  bp_fe_queue_s fe_queue_i,
   input  logic         fe_queue_v_i,
   output logic         fe_queue_ready_o,
   output bp_fe_queue_s fe_queue_o,
   output logic         fe_queue_v_o,
   input  logic         fe_queue_yumi_i
);
   localparam int lg_els_lp = $clog2(els_p);
   localparam int ptr_width_lp = lg_els_lp + 1;
   logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next;
   logic full, empty, enq, yumi;
   bp_fe_queue_s mem_data;
   assign full = `BP_BE_PTR_FULL(wptr, cptr, ptr_width_lp);
   assign empty = `BP_BE_PTR_EMPTY(rptr, wptr);
   assign cptr_next = cptr + ptr_width_lp'(deq_v_i);
   assign fe_queue_ready_o = ~full;
   assign enq = fe_queue_v_i & ~full & ~clr_v_i;
   assign yumi = fe_queue_yumi_i & ~clr_v_i & ~roll_v_i;
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass = empty & enq & ~roll_v_i;
   assign fe_queue_v_o = ~empty | bypass;
   assign fe_queue_o = bypass ? fe_queue_i : mem_data;
`else
   assign fe_queue_v_o = ~empty;
   assign fe_queue_o = mem_data;
`endif
   bp_be_ckpt_ptr #(.width_p(ptr_width_lp)) cptr_reg (
      .clk_i(clk_i), .reset_i(reset_i), .inc_i(deq_v_i),
      .load_v_i(1'b0), .load_i('0), .ptr_o(cptr)
   );
   // roll and clr both rewind issue to the oldest entry still uncommitted after this cycle's deq
   bp_be_ckpt_ptr #(.width_p(ptr_width_lp)) rptr_reg (
      .clk_i(clk_i), .reset_i(reset_i), .inc_i(yumi),
      .load_v_i(clr_v_i | roll_v_i), .load_i(cptr_next), .ptr_o(rptr)
   );
   bp_be_ckpt_ptr #(.width_p(ptr_width_lp)) wptr_reg (
      .clk_i(clk_i), .reset_i(reset_i), .inc_i(enq),
      .load_v_i(clr_v_i), .load_i(cptr_next), .ptr_o(wptr)
   );
   bsg_mem_1r1w #(.width_p(fe_queue_width_p), .els_p(els_p)) mem (
      .w_clk_i(clk_i), .w_v_i(enq), .w_addr_i(wptr[lg_els_lp-1:0]), .w_data_i(fe_queue_i),
      .r_addr_i(rptr[lg_els_lp-1:0]), .r_data_o(mem_data)
   );
   always_ff @(posedge clk_i)
      if (!reset_i) begin
         assert (!deq_v_i || (cptr != rptr));
         assert (!fe_queue_yumi_i || fe_queue_v_o);
      end
endmodule

// File: tb/tb_bp_be_fe_checkpoint_fifo.sv
// tb_bp_be_fe_checkpoint_fifo: randomized scoreboard bench for the checkpoint FIFO
module tb_bp_be_fe_checkpoint_fifo;
   import bp_be_pkg::*;
   localparam int ELS = 8;
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, reset_i = 1'b1, clr_v_i = 1'b0, deq_v_i = 1'b0, roll_v_i = 1'b0;
   logic fe_queue_v_i = 1'b0, fe_queue_yumi_i = 1'b0, fe_queue_ready_o, fe_queue_v_o;
   bp_fe_queue_s fe_queue_i = '0, fe_queue_o;
   always #5 clk = ~clk;
   bp_be_fe_checkpoint_fifo dut (
      .clk_i(clk), .reset_i(reset_i), .clr_v_i(clr_v_i), .deq_v_i(deq_v_i), .roll_v_i(roll_v_i),
      .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
      .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i)
   );
   bp_fe_queue_s q[$];
   bp_fe_queue_s exp_q[$];
   bp_fe_queue_s e;
   int issued = 0, seq = 0, n_cmp = 0, n_bad = 0;
   bit exp_v = 1'b0, exp_ready = 1'b1;
   always @(negedge clk)
      if (!reset_i) begin
         n_cmp++;
         if (fe_queue_v_o !== exp_v) begin
            n_bad++;
            $display("FAIL v_o @%0t: got %b want %b", $time, fe_queue_v_o, exp_v);
         end
         n_cmp++;
         if (fe_queue_ready_o !== exp_ready) begin
            n_bad++;
            $display("FAIL ready_o @%0t: got %b want %b", $time, fe_queue_ready_o, exp_ready);
         end
         if (fe_queue_yumi_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL issue @%0t: got %h want nothing", $time, fe_queue_o);
            end else begin
               e = exp_q.pop_front();
               if (fe_queue_o !== e) begin
                  n_bad++;
                  $display("FAIL issue @%0t: got %h want %h", $time, fe_queue_o, e);
               end
            end
         end
      end
   task automatic do_reset();
      reset_i = 1'b1;
      {fe_queue_v_i, fe_queue_yumi_i, deq_v_i, roll_v_i, clr_v_i} = '0;
      @(posedge clk);
      q.delete();
      issued = 0;
      exp_v = 1'b0;
      exp_ready = 1'b1;
      #1 reset_i = 1'b0;
   endtask
   // Model: q holds uncommitted packets oldest first; the first 'issued' of them have been issued.
   task automatic cycle(input bit v, input bit y, input bit d, input bit r, input bit c);
      logic [127:0] rnd;
      bp_fe_queue_s p;
      bit full, ie, acc, byp;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      p = rnd[$bits(bp_fe_queue_s)-1:0];
      p.instr = 32'(seq);
      seq++;
      full = q.size() == ELS;
      ie = issued == q.size();
      acc = v && !full && !c;
      byp = BYP && ie && acc && !r;
      exp_v = !ie || byp;
      exp_ready = !full;
      y = y && exp_v && !r && !c;
      d = d && issued > 0;
      fe_queue_i = p;
      fe_queue_v_i = v;
      fe_queue_yumi_i = y;
      deq_v_i = d;
      roll_v_i = r;
      clr_v_i = c;
      if (y) exp_q.push_back(ie ? p : q[issued]);
      @(posedge clk);
      if (d) begin
         void'(q.pop_front());
         issued--;
      end
      if (c) begin
         q.delete();
         issued = 0;
      end else begin
         if (r) issued = 0;
         if (acc) q.push_back(p);
         if (y) issued++;
      end
      #1;
   endtask
   initial begin
      do_reset();
      cycle(0, 0, 0, 0, 0);
      repeat (9) cycle(1, 0, 0, 0, 0);
      repeat (8) cycle(0, 1, 0, 0, 0);
      repeat (8) cycle(0, 0, 1, 0, 0);
      repeat (5) cycle(1, 0, 0, 0, 0);
      repeat (3) cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      repeat (4) cycle(0, 1, 0, 0, 0);
      repeat (4) cycle(0, 0, 1, 0, 0);
      repeat (4) cycle(1, 0, 0, 0, 0);
      repeat (2) cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) cycle(i < 20, 1, i >= 2, 0, 0);
      repeat (3) cycle(1, 0, 0, 0, 0);
      repeat (2) cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 1, 1);
      cycle(0, 0, 0, 0, 0);
      repeat (5) cycle(1, 0, 0, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0, 0);
      cycle(1, BYP, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      do_reset();
      repeat (3000)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      cycle(0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
